// File: rtl/gol_pkg.sv
// ---------------------------------------------------------------------------
// gol_pkg
// Shared definitions for the Game-of-Life field blocks.
//   FIELD_W_DEF / FIELD_H_DEF : default field size in cells
//   adrWidth()                : address width for a given axis length
//   cntWidth()                : width able to hold a count of 0..W*H
//   loader_state_e            : field loader FSM states
// ---------------------------------------------------------------------------
package gol_pkg;

    localparam int FIELD_W_DEF = 64;
    localparam int FIELD_H_DEF = 48;

    // An axis of length 1 would give a zero-width address, so clamp to 1 bit.
    function automatic int adrWidth(input int cells);
        return (cells > 1) ? $clog2(cells) : 1;
    endfunction

    function automatic int cntWidth(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } loader_state_e;

endpackage

// File: rtl/field_loader_if.sv
// ---------------------------------------------------------------------------
// field_loader_if
// Control, ROM-read and field-RAM-write signals of the field loader.
//   slave  : loader side (takes start/clear/ROM data, drives the rest)
//   master : controller / ROM / RAM side
// ---------------------------------------------------------------------------
interface field_loader_if
    import gol_pkg::*;
#(
    parameter int FIELD_W = FIELD_W_DEF,
    parameter int FIELD_H = FIELD_H_DEF
);

    localparam int X_ADR_SIZE = adrWidth(FIELD_W);
    localparam int Y_ADR_SIZE = adrWidth(FIELD_H);
    localparam int CNT_SIZE   = cntWidth(FIELD_W, FIELD_H);

    logic                  i_start;
    logic                  i_clear;
    logic                  o_busy;
    logic                  o_done;
    logic [X_ADR_SIZE-1:0] o_rom_x_adr;
    logic [Y_ADR_SIZE-1:0] o_rom_y_adr;
    logic                  i_rom_cell_state;
    logic                  o_wr_en;
    logic [X_ADR_SIZE-1:0] o_wr_x_adr;
    logic [Y_ADR_SIZE-1:0] o_wr_y_adr;
    logic                  o_wr_data;
    logic [CNT_SIZE-1:0]   o_pop_count;

    modport slave (
        input  i_start, i_clear, i_rom_cell_state,
        output o_busy, o_done, o_rom_x_adr, o_rom_y_adr,
               o_wr_en, o_wr_x_adr, o_wr_y_adr, o_wr_data, o_pop_count
    );

    modport master (
        output i_start, i_clear, i_rom_cell_state,
        input  o_busy, o_done, o_rom_x_adr, o_rom_y_adr,
               o_wr_en, o_wr_x_adr, o_wr_y_adr, o_wr_data, o_pop_count
    );

endinterface

// File: rtl/field_scan_counter.sv
// ---------------------------------------------------------------------------
// field_scan_counter
// Raster x/y counter over a FIELD_W x FIELD_H field.
//   i_clk, i_rst : clock, synchronous active-high reset
//   clear_i      : return to (0,0) (wins over inc_i)
//   inc_i        : advance one cell in raster order, wrapping at the end
//   x_o, y_o     : current cell
//   last_o       : current cell is (FIELD_W-1, FIELD_H-1)
// ---------------------------------------------------------------------------
module field_scan_counter
    import gol_pkg::*;
#(
    parameter int FIELD_W = FIELD_W_DEF,
    parameter int FIELD_H = FIELD_H_DEF,
    localparam int XW = adrWidth(FIELD_W),
    localparam int YW = adrWidth(FIELD_H)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          clear_i,
    input  logic          inc_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);

    localparam logic [XW-1:0] X_MAX = XW'(FIELD_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(FIELD_H - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    // Next position: wrap on the explicit maximum rather than on the natural
    // binary overflow so non-power-of-two sizes never leave the field.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (inc_i) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Position register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/field_loader.sv
// ---------------------------------------------------------------------------
// field_loader
// Copies the field configuration ROM into the live field RAM one cell per
// clock in raster order, or fills the field with zeros in clear mode, and
// reports how many live cells were written.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : field_loader_if.slave (start/clear, busy/done, ROM read
//                  address + data, RAM write strobe/address/data, pop count)
// ---------------------------------------------------------------------------
module field_loader
    import gol_pkg::*;
#(
    parameter int FIELD_W = FIELD_W_DEF,
    parameter int FIELD_H = FIELD_H_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst,
    field_loader_if.slave  bus
);

    localparam int X_ADR_SIZE = adrWidth(FIELD_W);
    localparam int Y_ADR_SIZE = adrWidth(FIELD_H);
    localparam int CNT_SIZE   = cntWidth(FIELD_W, FIELD_H);

    loader_state_e         state_q;
    logic                  mode_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  wrEn_q;
    logic [X_ADR_SIZE-1:0] wrX_q;
    logic [Y_ADR_SIZE-1:0] wrY_q;
    logic                  wrData_q;
    logic [CNT_SIZE-1:0]   popCount_q;

    logic [X_ADR_SIZE-1:0] scanX;
    logic [Y_ADR_SIZE-1:0] scanY;
    logic                  scanLast;
    logic                  scanClear;
    logic                  scanInc;

    // Counter is zeroed on an accepted start and steps every SCAN cycle; it
    // wraps back to (0,0) on the last cell, so IDLE always reads ROM (0,0).
    assign scanClear = (state_q == IDLE) && bus.i_start;
    assign scanInc   = (state_q == SCAN);

    field_scan_counter #(
        .FIELD_W (FIELD_W),
        .FIELD_H (FIELD_H)
    ) u_scan (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .clear_i (scanClear),
        .inc_i   (scanInc),
        .x_o     (scanX),
        .y_o     (scanY),
        .last_o  (scanLast)
    );

    // Loader FSM with a one-stage registered write port. The population count
    // follows the registered write, so the final cell is counted on the DRAIN
    // edge and the total is already complete when o_done rises.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wrEn_q     <= 1'b0;
            wrX_q      <= '0;
            wrY_q      <= '0;
            wrData_q   <= 1'b0;
            popCount_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (wrEn_q && wrData_q) begin
                popCount_q <= popCount_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    wrEn_q <= 1'b0;
                    if (bus.i_start) begin
                        mode_q     <= bus.i_clear;
                        popCount_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    wrEn_q   <= 1'b1;
                    wrX_q    <= scanX;
                    wrY_q    <= scanY;
                    wrData_q <= mode_q ? 1'b0 : bus.i_rom_cell_state;
                    if (scanLast) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    wrEn_q  <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    wrEn_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_rom_x_adr = scanX;
    assign bus.o_rom_y_adr = scanY;
    assign bus.o_wr_en     = wrEn_q;
    assign bus.o_wr_x_adr  = wrX_q;
    assign bus.o_wr_y_adr  = wrY_q;
    assign bus.o_wr_data   = wrData_q;
    assign bus.o_pop_count = popCount_q;

endmodule

// File: doc/field_loader.md
Name: field_loader

Overview:
- Downstream consumer of the field configuration ROM.
- On request, raster-scans every cell address of the ROM and copies each cell state into the live field state memory (the one the generation engine updates), one cell per clock.
- Also supports a clear mode that writes all zeros.
- Reports the number of live cells written.
- Sits between the configuration ROM and the field RAM write port; driven by the top-level control FSM (power-up load, user reload or clear).

Parameters:
- FIELD_W, 64, field width in cells; any value ≥ 2, need not be a power of two.
- FIELD_H, 48, field height in cells; any value ≥ 2.
- X_ADR_SIZE (localparam), $clog2(FIELD_W), x address width.
- Y_ADR_SIZE (localparam), $clog2(FIELD_H), y address width.
- CNT_SIZE (localparam), $clog2(FIELD_W*FIELD_H+1), population count width.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  start request; sampled only in IDLE.
- i_clear  in  1  mode; sampled with i_start. 1 = write zeros, 0 = copy ROM.
- o_busy  out  1  high while not IDLE.
- o_done  out  1  single-cycle completion pulse.
- o_rom_x_adr  out  X_ADR_SIZE  ROM x read address.
- o_rom_y_adr  out  Y_ADR_SIZE  ROM y read address.
- i_rom_cell_state  in  1  ROM data; combinational from the address, same cycle.
- o_wr_en  out  1  field RAM write strobe.
- o_wr_x_adr  out  X_ADR_SIZE  write x address.
- o_wr_y_adr  out  Y_ADR_SIZE  write y address.
- o_wr_data  out  1  cell state to write.
- o_pop_count  out  CNT_SIZE  live cells written by the last completed load.

Behaviour:
- Reset: state IDLE. All outputs are 0, including o_pop_count, both address pairs, o_wr_en and o_done.
- Reset mid-operation aborts immediately: no further writes and no o_done.
- States: IDLE, SCAN, DRAIN.
- IDLE:
  - ROM address held at (0,0); o_wr_en = 0.
  - On i_start = 1: latch i_clear into a mode register, clear o_pop_count and the scan counters, then go to SCAN.
- SCAN:
  - Each cycle, the ROM address is the current (x,y).
  - At the clock edge, the write stage registers wr_en = 1, wr_adr = (x,y), and wr_data = mode ? 0 : i_rom_cell_state.
  - o_pop_count increments when the registered data is 1.
  - x increments; when x == FIELD_W-1, x wraps to 0 and y increments.
  - When (x,y) == (FIELD_W-1, FIELD_H-1), go to DRAIN; counters return to (0,0).
- DRAIN:
  - The last write is presented this cycle.
  - At the next edge: o_wr_en ← 0, o_done ← 1, state → IDLE.
- Timing, with N = FIELD_W*FIELD_H:
  - o_busy rises the cycle after i_start is sampled and stays high for N+1 cycles.
  - o_wr_en is high for exactly N consecutive cycles, starting one cycle after o_busy rises.
  - o_done is high for 1 cycle, immediately after the last write cycle.
- Write order is raster: (0,0), (1,0) … (FIELD_W-1,0), (0,1) … (FIELD_W-1, FIELD_H-1).
- Addresses never exceed FIELD_W-1 / FIELD_H-1, including for non-power-of-two sizes.
- i_start while busy is ignored; i_clear is ignored outside the start sample.
- i_start high in the o_done cycle (state IDLE) is accepted. Continuous i_start gives back-to-back loads with exactly one IDLE cycle between them.
- o_pop_count is stable from o_done until the next accepted start. In clear mode it ends at 0.

Decomposition:
- Shared package gol_pkg holds:
  - the FIELD_W / FIELD_H defaults;
  - the address-width helper constants;
  - the loader state enum (IDLE, SCAN, DRAIN).
- Sub-module field_scan_counter:
  - x/y raster counter with synchronous clear, increment enable, wrap and a "last" flag;
  - parameterised by FIELD_W / FIELD_H;
  - reused later by the display scanner.

Test Plan:
- Reset: assert i_rst for 2 cycles with i_start = 1 → all outputs 0, o_busy = 0, no writes.
- Copy, FIELD_W=4, FIELD_H=3, behavioural ROM model holding a glider (5 live cells) → 12 writes in raster order with data matching the ROM; o_done exactly 13 cycles after o_busy rises; o_pop_count = 5; o_busy = 0 in the cycle after o_done.
- Clear mode: same ROM, i_clear = 1 at start → 12 writes all with data 0; o_pop_count = 0; o_done after the same latency.
- Handshake: pulse i_start during write 4 → ignored, still 12 writes and one o_done. Then hold i_start high → second load begins with one IDLE cycle after o_done and o_pop_count cleared at its start.
- Abort: assert i_rst during write 6 → o_wr_en = 0 the next cycle, no o_done, counters at 0; a fresh start then completes all 12 writes correctly.
- Non-power-of-two, FIELD_W=5, FIELD_H=3 → 15 writes; x wraps after 4; x addresses 5–7 never appear; o_pop_count matches the model.
